// File: rtl/br_cmp_arbiter_pkg.sv
// Shared types and helpers for the branch-comparator arbiter.
//   arb_state_t : controller states (IDLE, CMP, RESP)
//   F3_*        : branch funct3 encodings
//   cmp_req_t   : latched request (operands, condition, owner ID)
//   f3_is_*     : funct3 classification helpers
//   decode_taken: turns raw eq/lt into the branch outcome
package br_cmp_pkg;

   localparam int CMP_XLEN    = 32;
   localparam int CMP_IDW_MAX = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMP  = 2'd1,
      RESP = 2'd2
   } arb_state_t;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef struct packed {
      logic [CMP_XLEN-1:0]    a;
      logic [CMP_XLEN-1:0]    b;
      logic [2:0]             funct3;
      logic [CMP_IDW_MAX-1:0] id;
   } cmp_req_t;

   // 010/011 have no branch meaning.
   function automatic logic f3_is_illegal(input logic [2:0] f3);
      return (f3[2:1] == 2'b01);
   endfunction

   // Only BLTU/BGEU compare unsigned; the illegal codes 010/011 also have
   // funct3[1] set but must still compare signed, so bit 2 is checked too.
   function automatic logic f3_is_unsigned(input logic [2:0] f3);
      return (f3[2:1] == 2'b11);
   endfunction

   function automatic logic decode_taken(input logic [2:0] f3,
                                         input logic eq,
                                         input logic lt);
      logic taken;
      case (f3)
         F3_BEQ:  taken = eq;
         F3_BNE:  taken = ~eq;
         F3_BLT:  taken = lt;
         F3_BGE:  taken = ~lt;
         F3_BLTU: taken = lt;
         F3_BGEU: taken = ~lt;
         default: taken = 1'b0;
      endcase
      return taken;
   endfunction

endpackage

// File: rtl/br_cmp_arbiter_branch_comp.sv
// Branch_comp: combinational equality / less-than comparator.
//   a, b  : operands
//   br_un : 1 = unsigned compare, 0 = signed compare
//   br_eq : a == b
//   br_lt : a < b under the selected signedness
module Branch_comp #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            br_un,
   output logic            br_eq,
   output logic            br_lt
);

   // Equality and signed/unsigned magnitude compare
   always_comb begin
      br_eq = (a == b);
      if (br_un) begin
         br_lt = (a < b);
      end else begin
         br_lt = ($signed(a) < $signed(b));
      end
   end

endmodule

// File: rtl/br_cmp_arbiter.sv
// br_cmp_arbiter: shares one Branch_comp between NREQ requesters.
// Round-robin grant over valid/ready channels; the accepted request is
// latched, compared in the following cycle and answered on a single
// tagged response channel two cycles after the handshake.
// XLEN must equal br_cmp_pkg::CMP_XLEN (operands are held in cmp_req_t).
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/req_ready : per-requester handshake (ready is one-hot)
//   req_a/req_b         : per-requester operands
//   req_funct3          : per-requester branch condition
//   resp_valid          : one-cycle result pulse
//   resp_id             : owner of the result
//   resp_taken/eq/lt    : decoded outcome and raw compare flags
//   resp_err            : illegal funct3 (010/011)
module br_cmp_arbiter
   import br_cmp_pkg::*;
#(
   parameter int XLEN = CMP_XLEN,
   parameter int NREQ = 2,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NREQ-1:0]           req_valid,
   output logic [NREQ-1:0]           req_ready,
   input  logic [NREQ-1:0][XLEN-1:0] req_a,
   input  logic [NREQ-1:0][XLEN-1:0] req_b,
   input  logic [NREQ-1:0][2:0]      req_funct3,
   output logic                      resp_valid,
   output logic [IDW-1:0]            resp_id,
   output logic                      resp_taken,
   output logic                      resp_eq,
   output logic                      resp_lt,
   output logic                      resp_err
);

   arb_state_t      state_r;
   arb_state_t      state_next_s;
   logic [IDW-1:0]  last_grant_r;
   logic [IDW-1:0]  grant_id_s;
   logic [NREQ-1:0] grant_s;
   logic            grant_found_s;
   logic            handshake_s;
   cmp_req_t        op_r;
   logic            br_un_s;
   logic            cmp_eq_s;
   logic            cmp_lt_s;

   // Round-robin pick: first valid requester after last_grant_r, wrapping
   always_comb begin
      logic [IDW-1:0] idx;
      idx           = '0;
      grant_s       = '0;
      grant_id_s    = '0;
      grant_found_s = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         idx = IDW'((int'(last_grant_r) + 1 + k) % NREQ);
         if (!grant_found_s && req_valid[idx]) begin
            grant_s[idx]  = 1'b1;
            grant_id_s    = idx;
            grant_found_s = 1'b1;
         end else begin
            grant_found_s = grant_found_s;
         end
      end
   end

   // Grant is exposed only while the controller can take a new request
   always_comb begin
      if ((state_r == IDLE) || (state_r == RESP)) begin
         req_ready = grant_s;
      end else begin
         req_ready = '0;
      end
   end

   assign handshake_s = |(req_valid & req_ready);

   // Next-state logic; RESP chains straight into CMP on a new handshake
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE:    state_next_s = handshake_s ? CMP : IDLE;
         CMP:     state_next_s = RESP;
         RESP:    state_next_s = handshake_s ? CMP : IDLE;
         default: state_next_s = IDLE;
      endcase
   end

   // Controller state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Capture the granted request and advance the round-robin pointer
   always_ff @(posedge clk) begin
      if (rst) begin
         op_r         <= '0;
         last_grant_r <= IDW'(NREQ - 1);
      end else if (handshake_s) begin
         op_r.a       <= req_a[grant_id_s];
         op_r.b       <= req_b[grant_id_s];
         op_r.funct3  <= req_funct3[grant_id_s];
         op_r.id      <= CMP_IDW_MAX'(grant_id_s);
         last_grant_r <= grant_id_s;
      end else begin
         op_r         <= op_r;
         last_grant_r <= last_grant_r;
      end
   end

   assign br_un_s = f3_is_unsigned(op_r.funct3);

   Branch_comp #(
      .XLEN (XLEN)
   ) u_branch_comp (
      .a     (op_r.a),
      .b     (op_r.b),
      .br_un (br_un_s),
      .br_eq (cmp_eq_s),
      .br_lt (cmp_lt_s)
   );

   // Result registers: loaded at the end of CMP, held until the next result
   always_ff @(posedge clk) begin
      if (rst) begin
         resp_valid <= 1'b0;
         resp_id    <= '0;
         resp_taken <= 1'b0;
         resp_eq    <= 1'b0;
         resp_lt    <= 1'b0;
         resp_err   <= 1'b0;
      end else begin
         resp_valid <= (state_r == CMP);
         if (state_r == CMP) begin
            resp_id    <= op_r.id[IDW-1:0];
            resp_taken <= decode_taken(op_r.funct3, cmp_eq_s, cmp_lt_s);
            resp_eq    <= cmp_eq_s;
            resp_lt    <= cmp_lt_s;
            resp_err   <= f3_is_illegal(op_r.funct3);
         end
      end
   end

endmodule
